// File: rtl/exe_sched.sv
// Execute-stage scheduler: routes one ID instruction to the ALU or the iterative MDU; optional perf counters via EXE_PERF_CNT_EN.
// Latency: ALU result valid 2 cycles after accept; MDU result valid 1 cycle after i_mdu_done (or after the MDU_TO watchdog).
// Backpressure: result held in OUT until i_ex_ready; o_id_ready only in IDLE or on the OUT handshake cycle (back-to-back issue).
module exe_sched #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned MDU_TO = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [7:0]      i_inst_opcode,
    input  logic            i_use_mdu,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [XLEN-1:0] i_op3,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_wen,
    input  logic            i_flush,
    output logic            o_alu_ena,
    output logic [7:0]      o_alu_opcode,
    output logic [XLEN-1:0] o_alu_op1,
    output logic [XLEN-1:0] o_alu_op2,
    output logic [XLEN-1:0] o_alu_op3,
    input  logic [XLEN-1:0] i_alu_rd_wdata,
    input  logic            i_alu_pc_jmp,
    input  logic [XLEN-1:0] i_alu_pc_jmpaddr,
    output logic            o_mdu_start,
    output logic            o_mdu_kill,
    output logic [7:0]      o_mdu_opcode,
    output logic [XLEN-1:0] o_mdu_op1,
    output logic [XLEN-1:0] o_mdu_op2,
    input  logic            i_mdu_done,
    input  logic [XLEN-1:0] i_mdu_result,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_rd_wen,
    output logic [XLEN-1:0] o_ex_wdata,
    output logic            o_ex_pc_jmp,
    output logic [XLEN-1:0] o_ex_pc_jmpaddr,
    output logic            o_mdu_timeout,
    output logic [63:0]     o_perf_alu_cnt,
    output logic [63:0]     o_perf_mdu_stall
);

    typedef enum logic [1:0] {S_IDLE, S_ALU, S_MDU_WAIT, S_OUT} state_t;

    state_t          state;
    state_t          state_nx;
    state_t          issue_st;
    logic [7:0]      opcode_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] op3_q;
    logic [4:0]      rd_q;
    logic            rd_wen_q;
    logic            mdu_first;
    logic [31:0]     wd_cnt;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] jmpaddr_q;
    logic            jmp_q;
    logic            ex_wen_q;
    logic            timeout_q;
    logic            accept;
    logic            mdu_done_ok;
    logic            wd_hit;

    assign o_id_ready  = !i_flush && (state == S_IDLE || (state == S_OUT && i_ex_ready));
    assign accept      = i_id_valid && o_id_ready;
    assign issue_st    = i_use_mdu ? S_MDU_WAIT : S_ALU;
    // A done arriving with flush is dropped; done beats the watchdog in the same cycle.
    assign mdu_done_ok = (state == S_MDU_WAIT) && i_mdu_done && !i_flush;
    assign wd_hit      = (MDU_TO != 0) && (state == S_MDU_WAIT) && !i_mdu_done && !i_flush
                         && ((wd_cnt + 32'd1) == MDU_TO);

    always_comb begin
        state_nx    = state;
        o_alu_ena   = 1'b0;
        o_mdu_start = 1'b0;
        o_mdu_kill  = 1'b0;
        o_ex_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = issue_st;
            end
            S_ALU: begin
                o_alu_ena = 1'b1;
                state_nx  = S_OUT;
            end
            S_MDU_WAIT: begin
                // Never start an MDU op that is being killed in the same cycle.
                o_mdu_start = mdu_first && !i_flush && !wd_hit;
                o_mdu_kill  = i_flush || wd_hit;
                if (mdu_done_ok || wd_hit) state_nx = S_OUT;
            end
            S_OUT: begin
                o_ex_valid = 1'b1;
                if (i_ex_ready) state_nx = accept ? issue_st : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (i_flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            opcode_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op3_q     <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            mdu_first <= 1'b0;
            wd_cnt    <= '0;
            wdata_q   <= '0;
            jmpaddr_q <= '0;
            jmp_q     <= 1'b0;
            ex_wen_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opcode_q  <= i_inst_opcode;
                op1_q     <= i_op1;
                op2_q     <= i_op2;
                op3_q     <= i_op3;
                rd_q      <= i_rd;
                rd_wen_q  <= i_rd_wen;
                mdu_first <= 1'b1;
                wd_cnt    <= '0;
            end
            if (state == S_MDU_WAIT) begin
                mdu_first <= 1'b0;
                wd_cnt    <= wd_cnt + 32'd1;
            end
            if (state == S_ALU) begin
                wdata_q   <= i_alu_rd_wdata;
                jmp_q     <= i_alu_pc_jmp;
                jmpaddr_q <= i_alu_pc_jmpaddr;
                ex_wen_q  <= rd_wen_q;
            end
            if (mdu_done_ok) begin
                wdata_q   <= i_mdu_result;
                jmp_q     <= 1'b0;
                jmpaddr_q <= '0;
                ex_wen_q  <= rd_wen_q;
            end
            // Timed-out op reports all-ones and must not write the register file.
            if (wd_hit) begin
                wdata_q   <= '1;
                jmp_q     <= 1'b0;
                jmpaddr_q <= '0;
                ex_wen_q  <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_alu_opcode    = opcode_q;
    assign o_alu_op1       = op1_q;
    assign o_alu_op2       = op2_q;
    assign o_alu_op3       = op3_q;
    assign o_mdu_opcode    = opcode_q;
    assign o_mdu_op1       = op1_q;
    assign o_mdu_op2       = op2_q;
    assign o_ex_rd         = rd_q;
    assign o_ex_rd_wen     = ex_wen_q;
    assign o_ex_wdata      = wdata_q;
    assign o_ex_pc_jmp     = jmp_q;
    assign o_ex_pc_jmpaddr = jmpaddr_q;
    assign o_mdu_timeout   = timeout_q;

`ifdef EXE_PERF_CNT_EN
    logic [63:0] perf_alu_q;
    logic [63:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_alu_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state == S_ALU) perf_alu_q <= perf_alu_q + 64'd1;
            if (state == S_MDU_WAIT || (state == S_OUT && !i_ex_ready))
                perf_stall_q <= perf_stall_q + 64'd1;
        end
    end

    assign o_perf_alu_cnt   = perf_alu_q;
    assign o_perf_mdu_stall = perf_stall_q;
`else
    assign o_perf_alu_cnt   = '0;
    assign o_perf_mdu_stall = '0;
`endif

endmodule

// File: tb/tb_exe_sched.sv
// Directed bench for exe_sched: ALU, MDU, back-to-back, flush, watchdog and perf counters.
module tb_exe_sched;
    localparam int unsigned TO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_id_valid, o_id_ready, i_use_mdu, i_rd_wen, i_flush;
    logic [7:0]  i_inst_opcode, o_alu_opcode, o_mdu_opcode;
    logic [63:0] i_op1, i_op2, i_op3;
    logic [4:0]  i_rd, o_ex_rd;
    logic        o_alu_ena, i_alu_pc_jmp, o_mdu_start, o_mdu_kill, i_mdu_done;
    logic [63:0] o_alu_op1, o_alu_op2, o_alu_op3, i_alu_rd_wdata, i_alu_pc_jmpaddr;
    logic [63:0] o_mdu_op1, o_mdu_op2, i_mdu_result;
    logic        o_ex_valid, i_ex_ready, o_ex_rd_wen, o_ex_pc_jmp, o_mdu_timeout;
    logic [63:0] o_ex_wdata, o_ex_pc_jmpaddr, o_perf_alu_cnt, o_perf_mdu_stall;

    int n_cmp = 0;
    int n_bad = 0;
    int starts, kills, alus;

    exe_sched #(.XLEN(64), .MDU_TO(TO)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_inst_opcode(i_inst_opcode), .i_use_mdu(i_use_mdu),
        .i_op1(i_op1), .i_op2(i_op2), .i_op3(i_op3),
        .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_flush(i_flush),
        .o_alu_ena(o_alu_ena), .o_alu_opcode(o_alu_opcode),
        .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2), .o_alu_op3(o_alu_op3),
        .i_alu_rd_wdata(i_alu_rd_wdata), .i_alu_pc_jmp(i_alu_pc_jmp),
        .i_alu_pc_jmpaddr(i_alu_pc_jmpaddr),
        .o_mdu_start(o_mdu_start), .o_mdu_kill(o_mdu_kill),
        .o_mdu_opcode(o_mdu_opcode), .o_mdu_op1(o_mdu_op1), .o_mdu_op2(o_mdu_op2),
        .i_mdu_done(i_mdu_done), .i_mdu_result(i_mdu_result),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_rd(o_ex_rd), .o_ex_rd_wen(o_ex_rd_wen), .o_ex_wdata(o_ex_wdata),
        .o_ex_pc_jmp(o_ex_pc_jmp), .o_ex_pc_jmpaddr(o_ex_pc_jmpaddr),
        .o_mdu_timeout(o_mdu_timeout),
        .o_perf_alu_cnt(o_perf_alu_cnt), .o_perf_mdu_stall(o_perf_mdu_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic mdu, input logic [7:0] opc, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic wen);
        i_id_valid    = 1'b1;
        i_use_mdu     = mdu;
        i_inst_opcode = opc;
        i_op1         = a;
        i_op2         = b;
        i_op3         = '0;
        i_rd          = rd;
        i_rd_wen      = wen;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_id_valid = 0; i_use_mdu = 0; i_inst_opcode = 0;
        i_op1 = 0; i_op2 = 0; i_op3 = 0; i_rd = 0; i_rd_wen = 0; i_flush = 0;
        i_alu_rd_wdata = 0; i_alu_pc_jmp = 0; i_alu_pc_jmpaddr = 0;
        i_mdu_done = 0; i_mdu_result = 0; i_ex_ready = 1;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", o_ex_valid, 0);
        check("rst_wdata", o_ex_wdata, 0);
        check("rst_alu_ena", o_alu_ena, 0);
        check("rst_mdu_start", o_mdu_start, 0);
        check("rst_mdu_kill", o_mdu_kill, 0);
        check("rst_timeout", o_mdu_timeout, 0);
        check("rst_perf_alu", o_perf_alu_cnt, 0);
        check("rst_perf_stall", o_perf_mdu_stall, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_id_ready", o_id_ready, 1);
        nxt();

        // ALU: 5 + 7 with 3 cycles of MEM backpressure
        issue(0, 8'h01, 64'd5, 64'd7, 5'd3, 1'b1);
        @(negedge clk);
        check("alu_acc_ready", o_id_ready, 1);
        nxt();
        i_id_valid = 0;
        i_alu_rd_wdata = 64'd12;
        @(negedge clk);
        check("alu_ena", o_alu_ena, 1);
        check("alu_op1", o_alu_op1, 64'd5);
        check("alu_op2", o_alu_op2, 64'd7);
        check("alu_opcode", o_alu_opcode, 8'h01);
        check("alu_no_start", o_mdu_start, 0);
        check("alu_valid_t1", o_ex_valid, 0);
        nxt();
        i_alu_rd_wdata = 64'hdead;
        i_ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("alu_hold_valid", o_ex_valid, 1);
            check("alu_hold_wdata", o_ex_wdata, 64'd12);
            check("alu_hold_rd", o_ex_rd, 5'd3);
            check("alu_hold_wen", o_ex_rd_wen, 1);
            check("alu_hold_ena", o_alu_ena, 0);
            nxt();
        end
        i_ex_ready = 1;
        @(negedge clk);
        check("alu_hs_valid", o_ex_valid, 1);
        nxt();
        @(negedge clk);
        check("alu_drain", o_ex_valid, 0);
        nxt();

        // Back-to-back ALU ops, second one a taken branch
        issue(0, 8'h01, 64'd1, 64'd2, 5'd7, 1'b1);
        @(negedge clk);
        nxt();
        issue(0, 8'h10, 64'd0, 64'd0, 5'd9, 1'b1);
        i_alu_rd_wdata = 64'd3;
        @(negedge clk);
        check("b2b_busy_ready", o_id_ready, 0);
        nxt();
        @(negedge clk);
        check("b2b_first_valid", o_ex_valid, 1);
        check("b2b_first_wdata", o_ex_wdata, 64'd3);
        check("b2b_first_rd", o_ex_rd, 5'd7);
        check("b2b_out_ready", o_id_ready, 1);
        nxt();
        i_id_valid = 0;
        i_alu_rd_wdata = 64'h55;
        i_alu_pc_jmp = 1;
        i_alu_pc_jmpaddr = 64'h1000;
        @(negedge clk);
        check("b2b_gap_valid", o_ex_valid, 0);
        check("b2b_second_ena", o_alu_ena, 1);
        check("b2b_second_opc", o_alu_opcode, 8'h10);
        nxt();
        i_alu_pc_jmp = 0;
        @(negedge clk);
        check("b2b_second_valid", o_ex_valid, 1);
        check("b2b_second_wdata", o_ex_wdata, 64'h55);
        check("b2b_jmp", o_ex_pc_jmp, 1);
        check("b2b_jmpaddr", o_ex_pc_jmpaddr, 64'h1000);
        check("b2b_second_rd", o_ex_rd, 5'd9);
        nxt();
        @(negedge clk);
        check("b2b_drain", o_ex_valid, 0);
        nxt();

        // MDU: 6 * 7, done on the 10th wait cycle
        issue(1, 8'h20, 64'd6, 64'd7, 5'd5, 1'b1);
        @(negedge clk);
        nxt();
        i_id_valid = 0;
        starts = 0;
        alus = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                i_mdu_done = 1;
                i_mdu_result = 64'd42;
            end
            @(negedge clk);
            starts += int'(o_mdu_start);
            alus += int'(o_alu_ena);
            if (k == 1) begin
                check("mdu_op1", o_mdu_op1, 64'd6);
                check("mdu_op2", o_mdu_op2, 64'd7);
                check("mdu_opcode", o_mdu_opcode, 8'h20);
            end
            if (k == 5) check("mdu_wait_valid", o_ex_valid, 0);
            nxt();
        end
        i_mdu_done = 0;
        check("mdu_start_pulses", starts, 1);
        check("mdu_no_alu_ena", alus, 0);
        @(negedge clk);
        check("mdu_valid", o_ex_valid, 1);
        check("mdu_wdata", o_ex_wdata, 64'd42);
        check("mdu_jmp", o_ex_pc_jmp, 0);
        check("mdu_rd", o_ex_rd, 5'd5);
        check("mdu_wen", o_ex_rd_wen, 1);
        nxt();
        @(negedge clk);
        check("mdu_drain", o_ex_valid, 0);
        nxt();

        // Flush in MDU_WAIT with a colliding done
        issue(1, 8'h21, 64'd3, 64'd3, 5'd4, 1'b1);
        @(negedge clk);
        nxt();
        i_id_valid = 0;
        @(negedge clk);
        check("fl_start", o_mdu_start, 1);
        nxt();
        i_flush = 1;
        i_mdu_done = 1;
        i_mdu_result = 64'd99;
        @(negedge clk);
        check("fl_kill", o_mdu_kill, 1);
        check("fl_no_start", o_mdu_start, 0);
        check("fl_ready", o_id_ready, 0);
        nxt();
        i_flush = 0;
        i_mdu_done = 0;
        @(negedge clk);
        check("fl_valid", o_ex_valid, 0);
        check("fl_idle_ready", o_id_ready, 1);
        check("fl_kill_off", o_mdu_kill, 0);
        check("fl_start_after_kill", o_mdu_start, 0);
        nxt();
        @(negedge clk);
        check("fl_valid2", o_ex_valid, 0);
        check("fl_discard", o_ex_wdata, 64'd42);
        nxt();

        // Stray done in IDLE
        i_mdu_done = 1;
        i_mdu_result = 64'd77;
        @(negedge clk);
        nxt();
        i_mdu_done = 0;
        @(negedge clk);
        check("stray_valid", o_ex_valid, 0);
        check("stray_wdata", o_ex_wdata, 64'd42);
        nxt();

        // Watchdog: done never comes
        issue(1, 8'h22, 64'd1, 64'd1, 5'd6, 1'b1);
        @(negedge clk);
        nxt();
        i_id_valid = 0;
        starts = 0;
        kills = 0;
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            starts += int'(o_mdu_start);
            if (k < int'(TO)) kills += int'(o_mdu_kill);
            else begin
                check("to_kill", o_mdu_kill, 1);
                check("to_flag_pre", o_mdu_timeout, 0);
            end
            nxt();
        end
        check("to_early_kill", kills, 0);
        check("to_start_pulses", starts, 1);
        i_ex_ready = 0;
        @(negedge clk);
        check("to_valid", o_ex_valid, 1);
        check("to_wdata", o_ex_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to_wen", o_ex_rd_wen, 0);
        check("to_flag", o_mdu_timeout, 1);
        check("to_rd", o_ex_rd, 5'd6);
        nxt();
        i_ex_ready = 1;
        @(negedge clk);
        check("to_hs_valid", o_ex_valid, 1);
        nxt();
        @(negedge clk);
        check("to_drain", o_ex_valid, 0);
        check("to_sticky", o_mdu_timeout, 1);
`ifdef EXE_PERF_CNT_EN
        check("perf_alu", o_perf_alu_cnt, 64'd3);
        check("perf_stall", o_perf_mdu_stall, 64'd28);
`else
        check("perf_alu_off", o_perf_alu_cnt, 64'd0);
        check("perf_stall_off", o_perf_mdu_stall, 64'd0);
`endif
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
